// File: rtl/hdmi_video_ctrl.sv
// HDMI video timing controller: pixel strobe divider, raster generator and upstream pixel scheduler.
// Optional colour-bar generator is compiled in with `define HDMI_CTRL_TESTPATTERN_EN.
module hdmi_video_ctrl #(
  parameter int DIV       = 10,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0
) (
  input  logic        pi_clk,
  input  logic        pi_rst,
  input  logic        pi_enable,
  input  logic        pi_pix_valid,
  input  logic        pi_pix_sof,
  input  logic [23:0] pi_pix_data,
  output logic        po_pix_ready,
  input  logic        pi_test_mode,
  output logic        po_pix_stb,
  output logic        po_de,
  output logic        po_hsync,
  output logic        po_vsync,
  output logic [7:0]  po_red,
  output logic [7:0]  po_green,
  output logic [7:0]  po_blue,
  output logic [10:0] po_hcount,
  output logic [9:0]  po_vcount,
  output logic        po_frame_start,
  output logic        po_underflow
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = $clog2(DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [10:0]   H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]   HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   H_LAST   = 11'(HT - 1);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]    VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]    V_LAST   = 10'(VT - 1);
  localparam logic          HS_ON    = (HSYNC_POL != 0);
  localparam logic          VS_ON    = (VSYNC_POL != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t         state;
  logic [DW-1:0]  div;
  logic [10:0]    h;
  logic [9:0]     v;
  logic           misalign;
  logic [23:0]    rgb;

  logic           stb;
  logic           wrap;
  logic           at_origin;
  logic           de_next;
  logic           hs_act;
  logic           vs_act;
  logic           sof_held;
  logic           run;
  logic           take;
  logic           starve;
  logic           bad_pix;
  logic           test_on;
  logic [23:0]    bar_rgb;
  logic [23:0]    pix_next;

  assign stb        = (div == DIV_LAST);
  assign po_pix_stb = stb;
  assign wrap       = (h == H_LAST) && (v == V_LAST);
  assign at_origin  = (h == '0) && (v == '0);
  assign de_next    = (h < H_ACT) && (v < V_ACT);
  assign hs_act     = (h >= HS_BEG) && (h < HS_END);
  assign vs_act     = (v >= VS_BEG) && (v < VS_END);
  assign sof_held   = pi_pix_valid && pi_pix_sof;
  assign run        = (state == S_RUN);

`ifdef HDMI_CTRL_TESTPATTERN_EN
  localparam int          BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [10:0] BAR_W11 = 11'(BAR_W);

  logic [10:0] bar_idx;

  assign test_on = pi_test_mode;

  always_comb begin
    bar_rgb = 24'h000000;
    bar_idx = h / BAR_W11;
    case (bar_idx)
      11'd0:   bar_rgb = 24'hFFFFFF;
      11'd1:   bar_rgb = 24'hFFFF00;
      11'd2:   bar_rgb = 24'h00FFFF;
      11'd3:   bar_rgb = 24'h00FF00;
      11'd4:   bar_rgb = 24'hFF00FF;
      11'd5:   bar_rgb = 24'hFF0000;
      11'd6:   bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end
`else
  logic unused_test_mode;

  assign unused_test_mode = pi_test_mode;
  assign test_on          = 1'b0;
  assign bar_rgb          = 24'h000000;
`endif

  // ALIGN drains the source until it offers an SOF pixel, then parks on it.
  always_comb begin
    po_pix_ready = 1'b0;
    case (state)
      S_ALIGN: po_pix_ready = !sof_held;
      S_RUN:   po_pix_ready = stb && de_next;
      default: po_pix_ready = 1'b0;
    endcase
    if (test_on) po_pix_ready = 1'b0;
  end

  assign take    = pi_pix_valid && po_pix_ready;
  assign starve  = run && de_next && !pi_pix_valid && !test_on;
  assign bad_pix = starve || (run && take && pi_pix_sof && !at_origin);

  always_comb begin
    pix_next = 24'h000000;
    if (run && de_next) begin
      if (test_on)           pix_next = bar_rgb;
      else if (pi_pix_valid) pix_next = pi_pix_data;
    end
  end

  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      state          <= S_IDLE;
      div            <= '0;
      h              <= '0;
      v              <= '0;
      misalign       <= 1'b0;
      rgb            <= '0;
      po_de          <= 1'b0;
      po_hsync       <= !HS_ON;
      po_vsync       <= !VS_ON;
      po_hcount      <= '0;
      po_vcount      <= '0;
      po_frame_start <= 1'b0;
      po_underflow   <= 1'b0;
    end else begin
      div <= stb ? '0 : div + 1'b1;
      if (stb) begin
        if (state == S_IDLE) begin
          h              <= '0;
          v              <= '0;
          misalign       <= 1'b0;
          rgb            <= '0;
          po_de          <= 1'b0;
          po_hsync       <= !HS_ON;
          po_vsync       <= !VS_ON;
          po_hcount      <= '0;
          po_vcount      <= '0;
          po_frame_start <= 1'b0;
          if (pi_enable) state <= S_ALIGN;
        end else begin
          if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
          end else begin
            h <= h + 1'b1;
          end
          po_hcount      <= h;
          po_vcount      <= v;
          po_de          <= de_next;
          po_hsync       <= hs_act ? HS_ON : !HS_ON;
          po_vsync       <= vs_act ? VS_ON : !VS_ON;
          po_frame_start <= at_origin;
          rgb            <= pix_next;
          if (starve) po_underflow <= 1'b1;
          // Frame boundary: disable beats realignment, which beats staying put.
          if (wrap) begin
            misalign <= 1'b0;
            if (!pi_enable) begin
              state <= S_IDLE;
            end else if (state == S_ALIGN) begin
              if (sof_held || test_on) state <= S_RUN;
            end else if (misalign) begin
              state <= S_ALIGN;
            end
          end else if (bad_pix) begin
            misalign <= 1'b1;
          end
        end
      end
    end
  end

  assign po_red   = rgb[23:16];
  assign po_green = rgb[15:8];
  assign po_blue  = rgb[7:0];

endmodule

// File: tb/tb_hdmi_video_ctrl.sv
// Scoreboard bench for hdmi_video_ctrl on a 16x8 raster with DIV=10.
// Colour-bar section is included when HDMI_CTRL_TESTPATTERN_EN is defined.
`timescale 1ns/1ps
module tb_hdmi_video_ctrl;
  localparam int DIV = 10;
  localparam int HT = 16;
  localparam int VT = 8;
  localparam int HA = 8;
  localparam int VA = 4;
  localparam int M_IDLE = 0;
  localparam int M_ALIGN = 1;
  localparam int M_RUN = 2;
  localparam logic [23:0] SOF_PIX = 24'h112233;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic pix_valid = 1'b0;
  logic pix_sof = 1'b0;
  logic [23:0] pix_data = 24'h0;
  logic test_mode = 1'b0;

  logic pix_ready, pix_stb, de, hsync, vsync, frame_start, underflow;
  logic [7:0] red, green, blue;
  logic [10:0] hcount;
  logic [9:0] vcount;

  hdmi_video_ctrl #(
    .DIV(DIV), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(0), .VSYNC_POL(0)
  ) dut (
    .pi_clk(clk), .pi_rst(rst), .pi_enable(enable),
    .pi_pix_valid(pix_valid), .pi_pix_sof(pix_sof), .pi_pix_data(pix_data),
    .po_pix_ready(pix_ready), .pi_test_mode(test_mode), .po_pix_stb(pix_stb),
    .po_de(de), .po_hsync(hsync), .po_vsync(vsync),
    .po_red(red), .po_green(green), .po_blue(blue),
    .po_hcount(hcount), .po_vcount(vcount),
    .po_frame_start(frame_start), .po_underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        uf;
    logic [23:0] rgb;
  } obs_t;

  obs_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  logic mon_en = 1'b0;
  logic pend = 1'b0;
  logic tm = 1'b0;
  logic uf_m = 1'b0;
  time t_last = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic obs_t cur_obs();
    obs_t o;
    o.h = hcount; o.v = vcount; o.de = de; o.hs = hsync; o.vs = vsync;
    o.fs = frame_start; o.uf = underflow; o.rgb = {red, green, blue};
    return o;
  endfunction

  function automatic obs_t reset_obs(input logic uf);
    obs_t o;
    o.h = '0; o.v = '0; o.de = 1'b0; o.hs = 1'b1; o.vs = 1'b1;
    o.fs = 1'b0; o.uf = uf; o.rgb = '0;
    return o;
  endfunction

  function automatic logic [23:0] pixval(input int hh, input int vv);
    return {8'hA0 + 8'(vv), 8'h50 + 8'(hh), 8'(hh * 16 + vv)};
  endfunction

  function automatic logic [23:0] bar(input int hh);
    case (hh)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Monitor: every strobe edge presents one output pixel, compared against the queue head.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (pend && mon_en) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL scoreboard: output pixel h=%0d v=%0d with no expected entry", hcount, vcount);
        end else begin
          e = q.pop_front();
          a = cur_obs();
          chk($sformatf("pix h=%0d v=%0d", e.h, e.v), 64'(a), 64'(e));
        end
      end
      pend = pix_stb;
    end
  end

  task automatic apply_reset();
    int cyc;
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    enable = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    @(negedge clk);
    chk("rst_outputs", 64'(cur_obs()), 64'(reset_obs(1'b0)));
    chk("rst_stb_ready", {pix_stb, pix_ready}, 2'b00);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    cyc = 1;
    while (!pix_stb && cyc < 3 * DIV) begin
      @(negedge clk);
      cyc++;
    end
    chk("first_strobe_cycle", cyc, DIV);
    t_last = $time;
    q.delete();
    @(negedge clk);
    #1 mon_en = 1'b1;
  endtask

  task automatic step(input int md, input int hh, input int vv, input logic val,
                      input logic sof, input logic [23:0] data, input logic en, input logic uf);
    int w;
    obs_t e;
    logic dn, rdy;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!pix_stb && w < 3 * DIV);
    if (!pix_stb) begin
      n_chk++;
      $display("FAIL strobe_timeout: none within %0d cycles, required every %0d", 3 * DIV, DIV);
      return;
    end
    chk("stb_period", 64'(($time - t_last) / 10), DIV);
    t_last = $time;
    enable = en; pix_valid = val; pix_sof = sof; pix_data = data;
    dn = (hh < HA) && (vv < VA);
    case (md)
      M_ALIGN: rdy = tm ? 1'b0 : !(val && sof);
      M_RUN:   rdy = tm ? 1'b0 : dn;
      default: rdy = 1'b0;
    endcase
    #1 chk($sformatf("ready h=%0d v=%0d", hh, vv), pix_ready, rdy);
    if (md == M_IDLE) begin
      e = reset_obs(uf);
    end else begin
      e.h = 11'(hh); e.v = 10'(vv); e.de = dn;
      e.hs = !(hh >= 10 && hh < 13);
      e.vs = !(vv >= 5 && vv < 7);
      e.fs = (hh == 0) && (vv == 0);
      e.uf = uf;
      e.rgb = '0;
      if (md == M_RUN && dn) e.rgb = tm ? bar(hh) : (val ? data : 24'h0);
    end
    q.push_back(e);
  endtask

  task automatic frame(input int md, input int hole, input int bad_sof, input int en_off,
                       input int sof_from, input int last);
    int hh, vv;
    logic val, sof, en;
    logic [23:0] d;
    for (int idx = 0; idx <= last; idx++) begin
      hh = idx % HT; vv = idx / HT;
      val = 1'b1; sof = 1'b0; d = pixval(hh, vv);
      if (md == M_RUN && idx == 0) begin sof = 1'b1; d = SOF_PIX; end
      if (md == M_ALIGN && idx >= sof_from) begin sof = 1'b1; d = SOF_PIX; end
      if (idx == hole) val = 1'b0;
      if (idx == bad_sof) sof = 1'b1;
      en = (idx < en_off);
      if (md == M_RUN && idx == hole && hh < HA && vv < VA && !tm) uf_m = 1'b1;
      step(md, hh, vv, val, sof, d, en, uf_m);
    end
  endtask

  initial begin
    apply_reset();
    repeat (50) step(M_IDLE, 0, 0, 1'b0, 1'b0, 24'h0, 1'b0, uf_m);
    step(M_IDLE, 0, 0, 1'b1, 1'b1, SOF_PIX, 1'b1, uf_m);
    frame(M_ALIGN, -1, -1, 999, 0, HT * VT - 1);
    frame(M_RUN, -1, -1, 999, 0, HT * VT - 1);
    // one starved active pixel at (3,1)
    frame(M_RUN, 19, -1, 999, 0, HT * VT - 1);
    frame(M_ALIGN, -1, -1, 999, 100, HT * VT - 1);
    // stray SOF at (2,0) and enable dropped at line 3: disable takes priority
    frame(M_RUN, -1, 2, 48, 0, HT * VT - 1);
    repeat (3) step(M_IDLE, 0, 0, 1'b0, 1'b0, 24'h0, 1'b0, uf_m);
    step(M_IDLE, 0, 0, 1'b1, 1'b1, SOF_PIX, 1'b1, uf_m);
    frame(M_ALIGN, -1, -1, 999, 0, HT * VT - 1);
    frame(M_RUN, -1, -1, 999, 0, 2 * HT + 5);
    @(negedge clk);
    #2 chk("underflow_sticky", underflow, 1'b1);
    apply_reset();
    uf_m = 1'b0;
    repeat (3) step(M_IDLE, 0, 0, 1'b0, 1'b0, 24'h0, 1'b0, uf_m);
`ifdef HDMI_CTRL_TESTPATTERN_EN
    tm = 1'b1;
    test_mode = 1'b1;
    step(M_IDLE, 0, 0, 1'b1, 1'b0, 24'h0, 1'b1, uf_m);
    frame(M_ALIGN, -1, -1, 999, 999, HT * VT - 1);
    frame(M_RUN, 5, -1, 999, 0, HT * VT - 1);
`endif
    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hdmi_video_ctrl.md
# hdmi_video_ctrl

Video timing controller and pixel scheduler for the HDMI output path. It runs on the serial bit clock and derives a pixel strobe every `DIV` cycles, which keeps it aligned with the serializer's 10-bit symbol load. It generates the raster (hcount/vcount, data-enable, hsync, vsync) and pulls 24-bit pixels from an upstream frame source with a valid/ready handshake. It feeds per-pixel RGB and control to the TMDS encoders, which then feed the serializer.

## Interface
Parameters:
- `DIV`, 10: bit-clock cycles per pixel. Minimum 2.
- `H_ACTIVE` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal timing, in pixels.
- `V_ACTIVE` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical timing, in lines.
- `HSYNC_POL` 0, `VSYNC_POL` 0: sync active level (0 = active-low).

Ports:
- `pi_clk` in 1: bit clock; the only clock.
- `pi_rst` in 1: synchronous, active-high reset.
- `pi_enable` in 1: run request. Sampled only at frame boundaries.
- `pi_pix_valid` in 1: upstream pixel valid.
- `pi_pix_sof` in 1: current upstream pixel is pixel (0,0) of a frame.
- `pi_pix_data` in 24: upstream pixel, {R,G,B}.
- `po_pix_ready` out 1: upstream ready. A pixel transfers when valid & ready.
- `pi_test_mode` in 1: selects the internal color bars (see Configuration).
- `po_pix_stb` out 1: one-cycle pixel strobe, period `DIV`.
- `po_de` out 1: active video.
- `po_hsync` out 1: horizontal sync.
- `po_vsync` out 1: vertical sync.
- `po_red`, `po_green`, `po_blue` out 8 each: pixel color, 0 outside active video.
- `po_hcount` out 11: horizontal position of the current output pixel.
- `po_vcount` out 10: vertical position of the current output pixel.
- `po_frame_start` out 1: one-strobe-wide pulse on pixel (0,0).
- `po_underflow` out 1: sticky flag; set when the pixel source starves active video.

## Operation
- Divider `div` counts 0..DIV-1 and wraps. `po_pix_stb` = 1 when `div` == DIV-1. The divider runs in every state.
- Raster counters `h` (0..HT-1) and `v` (0..VT-1), where HT = sum of the horizontal parameters and VT = sum of the vertical parameters.
  - Both advance only on strobe cycles and are held at 0 in IDLE.
  - `h` wraps to 0 and increments `v`; `v` wraps to 0 at VT-1.
- Region decode:
  - de = h < H_ACTIVE && v < V_ACTIVE.
  - hsync is active when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vsync uses the same rule with the vertical parameters.
- FSM states:
  - **IDLE**: outputs at reset values, ready = 0. Go to ALIGN when `pi_enable` = 1.
  - **ALIGN**: raster runs with black active video.
    - `po_pix_ready` = !(pi_pix_valid & pi_pix_sof). This is combinational: it discards pixels until an SOF pixel is presented, then holds that pixel.
    - Go to RUN on the strobe where the raster wraps to (0,0), provided an SOF pixel is held at that moment. Otherwise stay in ALIGN.
    - If `pi_enable` = 0 at the wrap, go to IDLE instead.
  - **RUN**:
    - On a strobe cycle with de for the next position, `po_pix_ready` = 1; otherwise ready = 0.
    - If valid: the pixel is consumed and driven out.
    - If not valid: output black, set `po_underflow`, and go to ALIGN at the end of the frame.
    - A consumed pixel with sof = 1 at any position other than (0,0) also counts as a misalignment and sends the FSM to ALIGN at the end of the frame.
    - At frame end with `pi_enable` = 0, go to IDLE.
- `pi_rst` mid-frame: everything returns to reset values on the next edge and the FSM goes to IDLE. There is no partial-line completion.
- `po_underflow` is cleared only by reset.
- Simultaneous events at frame end: reset has highest priority, then `pi_enable` = 0 (go to IDLE), then misalignment (go to ALIGN).

## Timing
- Reset values:
  - `po_pix_stb`, `po_de`, `po_frame_start`, `po_underflow`, `po_pix_ready` = 0.
  - RGB = 0; counts = 0.
  - `po_hsync` = !HSYNC_POL; `po_vsync` = !VSYNC_POL.
- All outputs except `po_pix_ready` and `po_pix_stb` are registered. They update on the edge that ends a strobe cycle and then hold for DIV cycles.
- Pixel accepted on strobe cycle N appears on RGB from cycle N+1. Latency is 1 cycle.
- The first strobe after reset release occurs DIV cycles later.

## Configuration
- `HDMI_CTRL_TESTPATTERN_EN` defined:
  - `pi_test_mode` = 1 forces `po_pix_ready` = 0 and outputs 8 vertical color bars of width H_ACTIVE/8, in the order white, yellow, cyan, green, magenta, red, blue, black.
  - FSM sequencing is unchanged, except that ALIGN goes directly to RUN at the next wrap and no underflow is ever flagged.
- `HDMI_CTRL_TESTPATTERN_EN` not defined: `pi_test_mode` is ignored and the pattern logic is absent.

## Test plan
Bench parameters: DIV=10; H 8/2/3/3 (HT=16); V 4/1/2/1 (VT=8).

- Reset, then hold `pi_enable` = 0 for 500 cycles → strobe every 10 cycles; `po_de` = 0; syncs = 1; counts = 0.
- Enable, with SOF pixel 0x112233 followed by a continuous stream → RUN from the second wrap (cycle 1290 after enable); pixel (0,0) shows 0x112233; `po_de` high 8 strobes per line on 4 lines; hsync low for h = 10..12; vsync low for v = 5..6.
- Deassert `pi_valid` for one active strobe in RUN → that pixel is 0; `po_underflow` = 1 and stays set; FSM in ALIGN at the next frame; ready discards non-SOF pixels.
- Drop `pi_enable` mid-frame → the frame completes, then IDLE with counts = 0 from (0,0).
- Assert `pi_rst` at h = 5, v = 2 in RUN → next cycle: all outputs at reset values; `po_underflow` cleared.
- With `HDMI_CTRL_TESTPATTERN_EN` and `pi_test_mode` = 1 → ready = 0; h = 0 gives 0xFFFFFF; h = 3 gives 0x00FF00; h = 7 gives 0x000000.
